sram_row_sequencer: RTL and testbench
=====================================

Name: sram_row_sequencer

Overview:
- Sits directly upstream of the 5-to-32 row decoder in the SRAM macro path.
- Accepts read/write burst requests and drives the decoder address `A`.
- Sequences the per-row phases: precharge, wordline, sense-amp enable and write-driver enable.
- Keeps `A` stable for the whole access, so the decoder's one-hot output `Z` is settled before any wordline fires.

Parameters:
- ADDR_W, 5: row address width; matches decoder input width (2^ADDR_W rows).
- PRE_CYC, 1: precharge duration in cycles; must be at least 1.
- WL_CYC, 2: wordline-high duration in cycles; must be at least 1.
- LEN_W, 3: burst-length field width; a burst is req_len+1 beats, max 8.

Ports:
- clk  input  1  single clock; all state on rising edge
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  block idle and able to accept
- req_we  input  1  1=write burst, 0=read burst
- req_addr  input  ADDR_W  starting row
- req_len  input  LEN_W  beats minus one
- A  output  ADDR_W  row address to decoder; registered
- precharge  output  1  bitline precharge enable
- wl_en  output  1  wordline enable (gates decoder Z onto wordlines)
- sae  output  1  sense-amp enable, reads only
- wr_drv  output  1  write-driver enable, writes only
- beat_done  output  1  one-cycle pulse at end of each beat
- beat_addr  output  ADDR_W  row completed, valid with beat_done
- busy  output  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock `clk`. Reset `reset` is asynchronous and active-high.
- Reset values:
  - All outputs 0; state IDLE; counters 0.
  - req_ready is 0 while reset is asserted and 1 in the first cycle after release.
- FSM states: IDLE, PRE, WL, SENSE, FIN.
- Accept:
  - A request is accepted when req_valid && req_ready, in IDLE only.
  - req_addr, req_we and req_len are latched on acceptance; the next state is PRE.
  - req_ready = (state==IDLE) && !reset.
- PRE:
  - precharge=1 for PRE_CYC cycles.
  - A takes the latched address on entry to the first PRE.
- WL:
  - wl_en=1 for WL_CYC cycles.
  - wr_drv=wl_en for a write burst; wr_drv stays 0 for a read burst.
  - Next state is SENSE for a read, FIN for a write.
- SENSE: sae=1 for exactly 1 cycle, then FIN.
- FIN:
  - beat_done=1 and beat_addr=A for 1 cycle.
  - If beats remain: A <= A+1 modulo 2^ADDR_W (31 wraps to 0), beat counter decrements, next state PRE.
  - Otherwise next state IDLE.
- Latency, measured from the acceptance cycle c (defaults):
  - Read: precharge c+1; wl_en c+2..c+3; sae c+4; beat_done c+5; req_ready high c+6.
  - Write: beat_done c+4; req_ready high c+5.
  - Per-beat period: read PRE_CYC+WL_CYC+2, write PRE_CYC+WL_CYC+1.
- Invariants, all checked every cycle:
  - precharge, wl_en, sae are mutually exclusive.
  - wr_drv implies wl_en.
  - A changes only on entry to PRE.
- req_valid while busy: ignored; no latching and no queuing.
- Reset mid-operation:
  - All enables drop asynchronously; the burst is abandoned.
  - No beat_done is issued for the interrupted beat.
  - A returns to 0.
- Phase counter width: $clog2(max(PRE_CYC,WL_CYC)+1).

Decomposition:
- Package sram_ctrl_pkg holds:
  - state enum (IDLE/PRE/WL/SENSE/FIN)
  - default ADDR_W, LEN_W, PRE_CYC, WL_CYC constants
- One natural sub-module, sram_phase_timer: loadable down-counter that asserts `expire` when it reaches 0.
  - Reloaded on each PRE/WL entry.
  - Instantiated once in the FSM.

Test Plan:
- Single read, addr 5, len 0, after reset release:
  - A=5 from c+1; precharge c+1; wl_en c+2..c+3; sae c+4.
  - beat_done c+5 with beat_addr=5; req_ready=1 at c+6.
  - Cascaded decoder: Z==32'h20 while wl_en.
- Single write, addr 12, len 0:
  - wr_drv=1 exactly c+2..c+3; sae never 1.
  - beat_done c+4 with beat_addr=12.
- Read burst, addr 30, len 3:
  - beat_addr sequence 30, 31, 0, 1 (wrap).
  - beat_done pulses at c+5, c+10, c+15, c+20; req_ready=0 until c+21.
- req_valid held high with addr 7 during a busy burst:
  - Not accepted; the running burst is unaffected.
  - Accepted in the first IDLE cycle; A=7 on the following cycle.
- Reset asserted during the WL phase of beat 2 of a 4-beat burst:
  - wl_en, A and busy are 0 in the same timestep.
  - No further beat_done; req_ready=1 in the cycle after release.
- Sweep single reads 0..31:
  - Each beat_addr==i and decoder Z==1<<i during wl_en.
  - Exclusivity assertions never fire.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared types and default geometry for the SRAM row sequencer.
// The state encoding and the sizing constants live here so the top and its timer agree.
package sram_ctrl_pkg;

    localparam int ADDR_W_DEF  = 5;
    localparam int LEN_W_DEF   = 3;
    localparam int PRE_CYC_DEF = 1;
    localparam int WL_CYC_DEF  = 2;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        WL,
        SENSE,
        FIN
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sram_phase_timer.sv
// Loadable down-counter that times the precharge and wordline phases.
// The expire output is high while the count sits at zero.
module sram_phase_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign expire = (count == '0);

endmodule

// File: rtl/sram_row_sequencer.sv
// Row-access sequencer feeding the 5-to-32 row decoder.
// It holds A steady for each beat and steps through precharge, wordline, sense and finish.
module sram_row_sequencer
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int PRE_CYC = PRE_CYC_DEF,
    parameter int WL_CYC  = WL_CYC_DEF,
    parameter int LEN_W   = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    output logic [ADDR_W-1:0] A,
    output logic              precharge,
    output logic              wl_en,
    output logic              sae,
    output logic              wr_drv,
    output logic              beat_done,
    output logic [ADDR_W-1:0] beat_addr,
    output logic              busy
);

    localparam int TW = $clog2(max_int(PRE_CYC, WL_CYC) + 1);

    state_t           state;
    state_t           state_next;
    logic             we_q;
    logic [LEN_W-1:0] beats_left;
    logic             accept;
    logic             load;
    logic [TW-1:0]    load_val;
    logic             expire;

    assign req_ready = (state == IDLE) && !reset;
    assign accept    = req_valid && req_ready;

    sram_phase_timer #(
        .W(TW)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .expire   (expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A only moves on the edge that enters PRE: at acceptance or when FIN starts the next beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            A          <= '0;
            we_q       <= 1'b0;
            beats_left <= '0;
        end else if (accept) begin
            A          <= req_addr;
            we_q       <= req_we;
            beats_left <= req_len;
        end else if (state == FIN && beats_left != '0) begin
            A          <= A + ADDR_W'(1);
            beats_left <= beats_left - LEN_W'(1);
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        load_val   = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = PRE;
                    load       = 1'b1;
                    load_val   = TW'(PRE_CYC - 1);
                end
            end
            PRE: begin
                if (expire) begin
                    state_next = WL;
                    load       = 1'b1;
                    load_val   = TW'(WL_CYC - 1);
                end
            end
            WL: begin
                if (expire) begin
                    state_next = we_q ? FIN : SENSE;
                end
            end
            SENSE: begin
                state_next = FIN;
            end
            FIN: begin
                if (beats_left != '0) begin
                    state_next = PRE;
                    load       = 1'b1;
                    load_val   = TW'(PRE_CYC - 1);
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Enables decode straight from state so an asynchronous reset drops them at once.
    assign precharge = (state == PRE);
    assign wl_en     = (state == WL);
    assign sae       = (state == SENSE);
    assign wr_drv    = (state == WL) && we_q;
    assign beat_done = (state == FIN);
    assign beat_addr = A;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_sram_row_sequencer.sv
// Directed, self-checking bench for sram_row_sequencer with a beat-address scoreboard.
// A small decoder model turns A into the one-hot Z the row decoder would drive.
module tb_sram_row_sequencer;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [4:0]  req_addr;
    logic [2:0]  req_len;
    logic [4:0]  A;
    logic        precharge;
    logic        wl_en;
    logic        sae;
    logic        wr_drv;
    logic        beat_done;
    logic [4:0]  beat_addr;
    logic        busy;
    logic [31:0] Z;

    int         total;
    int         bad;
    logic [4:0] sb[$];
    logic [4:0] prev_A;
    logic       prev_reset;

    sram_row_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .A         (A),
        .precharge (precharge),
        .wl_en     (wl_en),
        .sae       (sae),
        .wr_drv    (wr_drv),
        .beat_done (beat_done),
        .beat_addr (beat_addr),
        .busy      (busy)
    );

    assign Z = 32'd1 << A;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one request for a single cycle and records the beat addresses it should produce.
    task automatic applyStimulus(input logic we, input logic [4:0] addr, input logic [2:0] len);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_len   = len;
        for (int k = 0; k <= int'(len); k++) sb.push_back(addr + 5'(k));
        tick();
        req_valid = 1'b0;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while (!req_ready && n < 100) begin
            tick();
            n++;
        end
        checkOutput("idle_reached", req_ready, 1);
    endtask

    // Every-cycle invariants plus scoreboard retirement on each beat_done.
    always @(negedge clk) begin
        if (!reset) begin
            checkOutput("exclusive", ((32'(precharge) + 32'(wl_en) + 32'(sae)) <= 1), 1);
            checkOutput("wrdrv_implies_wl", (!wr_drv || wl_en), 1);
            if (!prev_reset && A !== prev_A) checkOutput("A_change_in_pre", precharge, 1);
            if (wl_en && sb.size() > 0) checkOutput("decoder_Z", Z, 32'd1 << sb[0]);
            if (beat_done) begin
                if (sb.size() == 0) checkOutput("beat_unexpected", beat_done, 0);
                else checkOutput("beat_addr", beat_addr, sb.pop_front());
            end
        end
        prev_A     <= A;
        prev_reset <= reset;
    end

    initial begin
        logic seen;
        total     = 0;
        bad       = 0;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_len   = '0;
        #3;
        checkOutput("rst_ready", req_ready, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_A", A, 0);
        checkOutput("rst_beat_done", beat_done, 0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        checkOutput("ready_after_release", req_ready, 1);

        $display("[TB] single read addr 5");
        checkOutput("rd_ready_c", req_ready, 1);
        applyStimulus(1'b0, 5'd5, 3'd0);
        checkOutput("rd_pre_c1", precharge, 1);
        checkOutput("rd_A_c1", A, 5);
        checkOutput("rd_wl_c1", wl_en, 0);
        tick();
        checkOutput("rd_wl_c2", wl_en, 1);
        checkOutput("rd_pre_c2", precharge, 0);
        checkOutput("rd_Z_c2", Z, 32'h20);
        tick();
        checkOutput("rd_wl_c3", wl_en, 1);
        tick();
        checkOutput("rd_sae_c4", sae, 1);
        checkOutput("rd_wl_c4", wl_en, 0);
        tick();
        checkOutput("rd_done_c5", beat_done, 1);
        checkOutput("rd_baddr_c5", beat_addr, 5);
        checkOutput("rd_sae_c5", sae, 0);
        tick();
        checkOutput("rd_ready_c6", req_ready, 1);
        checkOutput("rd_busy_c6", busy, 0);

        $display("[TB] single write addr 12");
        seen = 1'b0;
        applyStimulus(1'b1, 5'd12, 3'd0);
        checkOutput("wr_drv_c1", wr_drv, 0);
        checkOutput("wr_pre_c1", precharge, 1);
        seen |= sae;
        tick();
        checkOutput("wr_drv_c2", wr_drv, 1);
        seen |= sae;
        tick();
        checkOutput("wr_drv_c3", wr_drv, 1);
        seen |= sae;
        tick();
        checkOutput("wr_done_c4", beat_done, 1);
        checkOutput("wr_baddr_c4", beat_addr, 12);
        checkOutput("wr_drv_c4", wr_drv, 0);
        seen |= sae;
        tick();
        checkOutput("wr_ready_c5", req_ready, 1);
        checkOutput("wr_sae_never", seen, 0);

        $display("[TB] read burst addr 30 len 3");
        applyStimulus(1'b0, 5'd30, 3'd3);
        for (int k = 1; k <= 20; k++) begin
            checkOutput("burst_beat_done", beat_done, (k % 5 == 0));
            checkOutput("burst_ready", req_ready, 0);
            tick();
        end
        checkOutput("burst_ready_c21", req_ready, 1);

        $display("[TB] request held during busy burst");
        applyStimulus(1'b0, 5'd2, 3'd1);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 5'd7;
        req_len   = 3'd0;
        sb.push_back(5'd7);
        for (int k = 1; k <= 9; k++) begin
            checkOutput("held_ready", req_ready, 0);
            tick();
        end
        checkOutput("held_done_c10", beat_done, 1);
        checkOutput("held_A_c10", A, 3);
        tick();
        checkOutput("held_ready_c11", req_ready, 1);
        tick();
        req_valid = 1'b0;
        checkOutput("held_A_c12", A, 7);
        checkOutput("held_pre_c12", precharge, 1);
        waitIdle();

        $display("[TB] reset during WL of beat 2");
        applyStimulus(1'b0, 5'd10, 3'd3);
        repeat (6) tick();
        checkOutput("mid_wl_before", wl_en, 1);
        checkOutput("mid_A_before", A, 11);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("mid_wl_after", wl_en, 0);
        checkOutput("mid_A_after", A, 0);
        checkOutput("mid_busy_after", busy, 0);
        checkOutput("mid_ready_in_reset", req_ready, 0);
        sb.delete();
        tick();
        tick();
        reset = 1'b0;
        tick();
        checkOutput("mid_ready_release", req_ready, 1);
        seen = 1'b0;
        repeat (25) begin
            tick();
            seen |= beat_done;
        end
        checkOutput("mid_no_beat", seen, 0);

        $display("[TB] sweep single reads 0..31");
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b0, 5'(i), 3'd0);
            waitIdle();
        end
        tick();
        checkOutput("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
